// File: rtl/pc_unit_pkg.sv
// ============================================================================
//  Module      : pc_unit_pkg
//  Description : Shared architectural constants for the PC unit: opcodes,
//                pipeline stage codes, trap causes and sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

   localparam logic [6:0] RISCV_LOAD    = 7'b0000011;
   localparam logic [6:0] RISCV_OP_IMM  = 7'b0010011;
   localparam logic [6:0] RISCV_AUIPC   = 7'b0010111;
   localparam logic [6:0] RISCV_STORE   = 7'b0100011;
   localparam logic [6:0] RISCV_OP      = 7'b0110011;
   localparam logic [6:0] RISCV_LUI     = 7'b0110111;
   localparam logic [6:0] RISCV_BRANCH  = 7'b1100011;
   localparam logic [6:0] RISCV_JALR    = 7'b1100111;
   localparam logic [6:0] RISCV_JAL     = 7'b1101111;
   localparam logic [6:0] RISCV_SYSTEM  = 7'b1110011;

   localparam logic [2:0] STAGE_FETCH           = 3'd0;
   localparam logic [2:0] STAGE_DECODE          = 3'd1;
   localparam logic [2:0] STAGE_EXECUTE         = 3'd2;
   localparam logic [2:0] STAGE_MEMORY          = 3'd3;
   localparam logic [2:0] STAGE_REGISTER_UPDATE = 3'd4;

   localparam int unsigned CAUSE_INSN_MISALIGNED = 0;
   localparam int unsigned CAUSE_ILLEGAL_INSN    = 2;

   typedef enum logic [0:0] {
      PCU_RUN  = 1'b0,
      PCU_TRAP = 1'b1
   } pcu_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC target, link address and alignment
//                check. Macro RISCV_C_EXT_EN enables 16-bit instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_calc
   import pc_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [6:0]      opcode,
   input  logic            jump_condition,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] rs1,
   input  logic            inst_len16,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc_link,
   output logic            misaligned
);

   logic [XLEN-1:0] w_step;
   logic [XLEN-1:0] w_jalr_sum;

`ifdef RISCV_C_EXT_EN
   assign w_step     = inst_len16 ? XLEN'(2) : XLEN'(4);
   // JALR clears bit0 and every other target is 2-byte aligned
   assign misaligned = 1'b0;
`else
   logic w_unused_len16;
   assign w_unused_len16 = inst_len16;
   assign w_step         = XLEN'(4);
   assign misaligned     = target[1];
`endif

   assign pc_link    = pc + w_step;
   assign w_jalr_sum = rs1 + offset;

   always_comb begin
      target = pc_link;
      case (opcode)
         RISCV_BRANCH: target = jump_condition ? (pc + offset) : pc_link;
         RISCV_JAL:    target = pc + offset;
         RISCV_JALR:   target = w_jalr_sum & ~XLEN'(1);
         default:      target = pc_link;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
//  Module      : pc_unit
//  Description : Architectural PC register with trap entry / MRET sequencer.
//                Macro RISCV_C_EXT_EN selects IALIGN=16 behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              CAUSE_W      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic [2:0]         stage,
   input  logic               stall,
   input  logic               jump_condition,
   input  logic [XLEN-1:0]    offset,
   input  logic [XLEN-1:0]    rs1,
   input  logic               mret,
   input  logic               ext_trap,
   input  logic [CAUSE_W-1:0] ext_cause,
   input  logic [XLEN-1:0]    trap_vector,
   input  logic               inst_len16,
   output logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    pc_link,
   output logic [XLEN-1:0]    mepc,
   output logic [CAUSE_W-1:0] mcause,
   output logic               trap_busy
);

   pcu_state_t         r_state;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_mepc;
   logic [CAUSE_W-1:0] r_mcause;

   logic [XLEN-1:0]    w_target;
   logic               w_misaligned;
   logic               w_update;
   logic [XLEN-1:0]    w_handler;

   pc_next_calc #(
      .XLEN (XLEN)
   ) u_next (
      .pc             (r_pc),
      .opcode         (opcode),
      .jump_condition (jump_condition),
      .offset         (offset),
      .rs1            (rs1),
      .inst_len16     (inst_len16),
      .target         (w_target),
      .pc_link        (pc_link),
      .misaligned     (w_misaligned)
   );

`ifdef RISCV_C_EXT_EN
   assign w_handler = trap_vector & ~XLEN'(1);
`else
   assign w_handler = trap_vector & ~XLEN'(3);
`endif

   assign w_update = (r_state == PCU_RUN) && (stage == STAGE_REGISTER_UPDATE) && !stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= PCU_RUN;
         r_pc     <= RESET_VECTOR;
         r_mepc   <= '0;
         r_mcause <= '0;
      end else begin
         case (r_state)
            PCU_RUN: begin
               if (w_update) begin
                  // Trapping instructions keep pc; the handler is loaded next cycle
                  if (ext_trap) begin
                     r_mepc   <= r_pc;
                     r_mcause <= ext_cause;
                     r_state  <= PCU_TRAP;
                  end else if (w_misaligned) begin
                     r_mepc   <= r_pc;
                     r_mcause <= CAUSE_W'(CAUSE_INSN_MISALIGNED);
                     r_state  <= PCU_TRAP;
                  end else if (mret) begin
                     r_pc <= r_mepc;
                  end else begin
                     r_pc <= w_target;
                  end
               end
            end
            PCU_TRAP: begin
               r_pc    <= w_handler;
               r_state <= PCU_RUN;
            end
            default: r_state <= PCU_RUN;
         endcase
      end
   end

   assign pc        = r_pc;
   assign mepc      = r_mepc;
   assign mcause    = r_mcause;
   assign trap_busy = (r_state == PCU_TRAP);

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit (directed table, corner
//                sequences, randomized run against a reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;
   import pc_unit_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0100;
   localparam logic [31:0] TV = 32'h8000_0006;
`ifdef RISCV_C_EXT_EN
   localparam bit C_EN = 1'b1;
`else
   localparam bit C_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic [2:0]  stage;
   logic        stall;
   logic        jump_condition;
   logic [31:0] offset;
   logic [31:0] rs1;
   logic        mret;
   logic        ext_trap;
   logic [3:0]  ext_cause;
   logic [31:0] trap_vector;
   logic        inst_len16;
   logic [31:0] pc;
   logic [31:0] pc_link;
   logic [31:0] mepc;
   logic [3:0]  mcause;
   logic        trap_busy;

   pc_unit #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .CAUSE_W      (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .opcode         (opcode),
      .stage          (stage),
      .stall          (stall),
      .jump_condition (jump_condition),
      .offset         (offset),
      .rs1            (rs1),
      .mret           (mret),
      .ext_trap       (ext_trap),
      .ext_cause      (ext_cause),
      .trap_vector    (trap_vector),
      .inst_len16     (inst_len16),
      .pc             (pc),
      .pc_link        (pc_link),
      .mepc           (mepc),
      .mcause         (mcause),
      .trap_busy      (trap_busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: architectural view of the unit
   logic [31:0] m_pc;
   logic [31:0] m_mepc;
   logic [3:0]  m_mcause;
   bit          m_trap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = RV;
      m_mepc   = '0;
      m_mcause = '0;
      m_trap   = 1'b0;
   endtask

   // apply one cycle of inputs, advance the model, and clock the DUT
   task automatic drive(input logic [6:0] op, input logic [31:0] off = 32'h0,
                        input logic [31:0] r1 = 32'h0, input logic cond = 1'b0,
                        input logic st = 1'b0, input logic [2:0] sg = STAGE_REGISTER_UPDATE,
                        input logic mr = 1'b0, input logic et = 1'b0,
                        input logic [3:0] ec = 4'h0, input logic l16 = 1'b0);
      logic [31:0] tgt;
      logic [31:0] stp;
      opcode = op; offset = off; rs1 = r1; jump_condition = cond; stall = st;
      stage = sg; mret = mr; ext_trap = et; ext_cause = ec; inst_len16 = l16;
      stp = (C_EN && l16) ? 32'd2 : 32'd4;
      if (m_trap) begin
         m_pc   = C_EN ? {trap_vector[31:1], 1'b0} : {trap_vector[31:2], 2'b00};
         m_trap = 1'b0;
      end else if (sg == STAGE_REGISTER_UPDATE && !st) begin
         if (op == RISCV_JAL || (op == RISCV_BRANCH && cond)) tgt = m_pc + off;
         else if (op == RISCV_JALR) tgt = (r1 + off) & 32'hFFFF_FFFE;
         else tgt = m_pc + stp;
         if (et) begin
            m_mepc = m_pc; m_mcause = ec; m_trap = 1'b1;
         end else if (!C_EN && tgt[1]) begin
            m_mepc = m_pc; m_mcause = 4'd0; m_trap = 1'b1;
         end else if (mr) begin
            m_pc = m_mepc;
         end else begin
            m_pc = tgt;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [31:0] a);
      drive(RISCV_JALR, 32'h0, a);
   endtask

   typedef struct {
      logic [31:0] start;
      logic [6:0]  op;
      logic        cond;
      logic [31:0] off;
      logic [31:0] r1;
      logic        st;
      logic [2:0]  sg;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{32'h200, RISCV_BRANCH, 1'b0, 32'h0,        32'h0,    1'b0, STAGE_REGISTER_UPDATE, 32'h204};
      vecs[1] = '{32'h200, RISCV_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'h0,   1'b0, STAGE_REGISTER_UPDATE, 32'h1F8};
      vecs[2] = '{32'h200, RISCV_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'h0,   1'b1, STAGE_REGISTER_UPDATE, 32'h200};
      vecs[3] = '{32'h500, RISCV_JAL,    1'b0, 32'h40,       32'h0,    1'b0, STAGE_REGISTER_UPDATE, 32'h540};
      vecs[4] = '{32'h500, RISCV_JALR,   1'b0, 32'h1,        32'h1003, 1'b0, STAGE_REGISTER_UPDATE, 32'h1004};
      vecs[5] = '{32'hFFFF_FFFC, RISCV_OP, 1'b0, 32'h0,      32'h0,    1'b0, STAGE_REGISTER_UPDATE, 32'h0};
      vecs[6] = '{32'h600, RISCV_OP,     1'b0, 32'h0,        32'h0,    1'b0, STAGE_EXECUTE,         32'h600};
      vecs[7] = '{32'h700, RISCV_JAL,    1'b0, 32'hFFFF_F900, 32'h0,   1'b0, STAGE_REGISTER_UPDATE, 32'h0};

      reset = 1'b1; opcode = RISCV_OP; stage = STAGE_FETCH; stall = 1'b0;
      jump_condition = 1'b0; offset = '0; rs1 = '0; mret = 1'b0; ext_trap = 1'b0;
      ext_cause = '0; trap_vector = TV; inst_len16 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      check("reset_pc", pc, 32'h100);
      check("reset_mepc", mepc, 32'h0);
      check("reset_mcause", {28'h0, mcause}, 32'h0);
      check("reset_busy", {31'h0, trap_busy}, 32'h0);

      repeat (4) drive(RISCV_OP);
      check("four_ops_pc", pc, 32'h110);
      check("four_ops_link", pc_link, 32'h114);

      for (int i = 0; i < 8; i++) begin
         set_pc(vecs[i].start);
         drive(vecs[i].op, vecs[i].off, vecs[i].r1, vecs[i].cond, vecs[i].st, vecs[i].sg);
         check($sformatf("vec%0d_pc", i), pc, vecs[i].exp);
      end

      // JALR to a halfword-aligned target
      set_pc(32'h300);
      drive(RISCV_JALR, 32'h2, 32'h1001);
`ifdef RISCV_C_EXT_EN
      check("jalr_c_pc", pc, 32'h1002);
      check("jalr_c_busy", {31'h0, trap_busy}, 32'h0);
`else
      check("jalr_mis_busy", {31'h0, trap_busy}, 32'h1);
      check("jalr_mis_pc_hold", pc, 32'h300);
      check("jalr_mis_mepc", mepc, 32'h300);
      check("jalr_mis_mcause", {28'h0, mcause}, 32'h0);
      drive(RISCV_OP);
      check("jalr_mis_handler", pc, 32'h8000_0004);
      check("jalr_mis_busy_done", {31'h0, trap_busy}, 32'h0);
`endif

      // external trap wins over a misaligned JAL, then MRET
      set_pc(32'h400);
      drive(RISCV_JAL, 32'h2, 32'h0, 1'b0, 1'b0, STAGE_REGISTER_UPDATE, 1'b0, 1'b1, 4'd2);
      check("ext_busy", {31'h0, trap_busy}, 32'h1);
      check("ext_mcause", {28'h0, mcause}, 32'h2);
      check("ext_mepc", mepc, 32'h400);
      drive(RISCV_OP, 32'h0, 32'h0, 1'b0, 1'b1, STAGE_FETCH);
`ifdef RISCV_C_EXT_EN
      check("ext_handler", pc, 32'h8000_0006);
`else
      check("ext_handler", pc, 32'h8000_0004);
`endif
      drive(RISCV_SYSTEM, 32'h0, 32'h0, 1'b0, 1'b1, STAGE_REGISTER_UPDATE, 1'b1);
      check("mret_stalled_busy", {31'h0, trap_busy}, 32'h0);
      drive(RISCV_SYSTEM, 32'h0, 32'h0, 1'b0, 1'b0, STAGE_REGISTER_UPDATE, 1'b1);
      check("mret_pc", pc, 32'h400);
      check("mret_mepc", mepc, 32'h400);
      check("mret_mcause", {28'h0, mcause}, 32'h2);

      // compressed step
      set_pc(32'h10);
      inst_len16 = 1'b1;
      #1;
`ifdef RISCV_C_EXT_EN
      check("len16_link", pc_link, 32'h12);
`else
      check("len16_link", pc_link, 32'h14);
`endif
      drive(RISCV_OP, 32'h0, 32'h0, 1'b0, 1'b0, STAGE_REGISTER_UPDATE, 1'b0, 1'b0, 4'h0, 1'b1);
`ifdef RISCV_C_EXT_EN
      check("len16_pc", pc, 32'h12);
`else
      check("len16_pc", pc, 32'h14);
`endif

      // reset asserted while in TRAP
      set_pc(32'h300);
      drive(RISCV_JAL, 32'h0, 32'h0, 1'b0, 1'b0, STAGE_REGISTER_UPDATE, 1'b0, 1'b1, 4'd2);
      check("rst_trap_busy", {31'h0, trap_busy}, 32'h1);
      reset = 1'b1;
      #1;
      check("rst_async_pc", pc, 32'h100);
      check("rst_async_busy", {31'h0, trap_busy}, 32'h0);
      check("rst_async_mepc", mepc, 32'h0);
      #1 reset = 1'b0;
      model_reset();
      drive(RISCV_OP, 32'h0, 32'h0, 1'b0, 1'b0, STAGE_EXECUTE);
      check("rst_no_handler", pc, 32'h100);

      // randomized run against the model
      for (int n = 0; n < 400; n++) begin
         logic [6:0]  rop;
         logic [31:0] roff;
         logic [31:0] rr1;
         logic [2:0]  rsg;
         logic        rmr;
         case ($urandom_range(0, 4))
            0: rop = RISCV_BRANCH;
            1: rop = RISCV_JAL;
            2: rop = RISCV_JALR;
            3: rop = RISCV_SYSTEM;
            default: rop = RISCV_OP;
         endcase
         roff = {{20{1'b0}}, 12'($urandom)};
         roff = {{20{roff[11]}}, roff[11:0]};
         roff = ($urandom_range(0, 1) == 0) ? (roff & 32'hFFFF_FFFC) : (roff & 32'hFFFF_FFFE);
         rr1  = $urandom;
         rsg  = ($urandom_range(0, 3) != 0) ? STAGE_REGISTER_UPDATE : 3'($urandom_range(0, 3));
         rmr  = (rop == RISCV_SYSTEM);
         drive(rop, roff, rr1, 1'($urandom), ($urandom_range(0, 6) == 0), rsg, rmr,
               ($urandom_range(0, 19) == 0), 4'($urandom), 1'($urandom));
         check($sformatf("rnd%0d_pc", n), pc, m_pc);
         check($sformatf("rnd%0d_mepc", n), mepc, m_mepc);
         check($sformatf("rnd%0d_mcause", n), {28'h0, mcause}, {28'h0, m_mcause});
         check($sformatf("rnd%0d_busy", n), {31'h0, trap_busy}, {31'h0, m_trap});
         check($sformatf("rnd%0d_link", n), pc_link, m_pc + ((C_EN && inst_len16) ? 32'd2 : 32'd4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor of the combinational next-PC logic. Owns the architectural PC register, computes the next PC for all control-flow opcodes, and detects instruction-address-misaligned targets.
- Runs a small trap/return sequencer covering trap entry, external trap requests from decode, and MRET.
- Sits between decode/ALU (condition, offset, rs1) and fetch (pc output), updating once per instruction in the register-update stage.

Parameters:
- XLEN, 32, datapath width of pc, offset, rs1, mepc, trap_vector.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits, must be IALIGN-aligned).
- CAUSE_W, 4, width of mcause field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  current instruction opcode (RISCV_* constants).
- stage  in  3  pipeline stage code; update happens only at STAGE_REGISTER_UPDATE.
- stall  in  1  blocks any PC update this cycle.
- jump_condition  in  1  branch comparison result.
- offset  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  rs1 value for JALR.
- mret  in  1  current instruction is MRET.
- ext_trap  in  1  decode-raised trap (e.g. illegal instruction).
- ext_cause  in  CAUSE_W  cause for ext_trap.
- trap_vector  in  XLEN  mtvec base (direct mode only).
- inst_len16  in  1  current instruction is 16-bit; used only with RISCV_C_EXT_EN.
- pc  out  XLEN  current PC, registered.
- pc_link  out  XLEN  pc + step, the return address for JAL/JALR, combinational.
- mepc  out  XLEN  saved exception PC, registered.
- mcause  out  CAUSE_W  saved cause, registered.
- trap_busy  out  1  high while in state TRAP; fetch must hold.

Behaviour:
- Reset, asynchronous: pc=RESET_VECTOR, mepc=0, mcause=0, state=RUN, trap_busy=0. A reset asserted during TRAP abandons the trap and leaves no mepc/mcause update.
- step = 4. With the C extension and inst_len16=1, step = 2.
- Target calculation, combinational, modulo 2^XLEN with wrap and no overflow flag:
  - BRANCH taken: pc+offset.
  - BRANCH not taken: pc+step. This is fixed explicitly and must not hold the previous value (no latch).
  - JAL: pc+offset.
  - JALR: (rs1+offset) with bit0 cleared.
  - otherwise: pc+step.
- misaligned = target[1] without the C extension; always 0 with it, since bit0 is always clear.
- Update event = state==RUN && stage==STAGE_REGISTER_UPDATE && !stall.
- States:
  - RUN:
    - On update event, priority order: ext_trap > misaligned > mret > normal.
    - ext_trap: mepc<=pc, mcause<=ext_cause, pc holds, next state TRAP.
    - misaligned: mepc<=pc, mcause<=0 (instruction address misaligned), pc holds, next state TRAP.
    - mret: pc<=mepc.
    - normal: pc<=target.
    - No update event: everything holds.
  - TRAP (exactly 1 cycle):
    - pc<=trap_vector with bits[1:0] cleared; next state RUN.
    - stage, stall and all other inputs are ignored.
- Latency: the new pc is visible the cycle after the update event. A trap reaches the handler 2 cycles after the event.
- stall=1 in the update stage holds pc, mepc, mcause and state.
- mepc and mcause are written only on trap entry; MRET does not modify them.

Optional Feature:
- Macro RISCV_C_EXT_EN.
- Defined: IALIGN=16. inst_len16 selects step 2, misaligned is tied to 0, and trap_vector bit1 is preserved (only bit0 cleared).
- Undefined: IALIGN=32. inst_len16 is ignored, step is always 4, and target[1]=1 raises a misaligned trap.

Decomposition:
- Extend the shared arch defines include: RISCV_* opcodes, STAGE_* codes, and CAUSE_INSN_MISALIGNED=0 / CAUSE_ILLEGAL_INSN=2 constants; add state encodings PCU_RUN/PCU_TRAP.
- One natural sub-module: pc_next_calc, purely combinational, computing target, step and misaligned. pc_unit holds the registers and the FSM.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_0100 -> pc=0x100, mepc=0, mcause=0, trap_busy=0. Four normal ALU ops in update stage -> pc=0x110.
- pc=0x200, BRANCH, jump_condition=0 -> pc=0x204. Same with jump_condition=1, offset=-8 -> pc=0x1F8. stall=1 on the update cycle -> pc holds.
- pc=0x300, JALR, rs1=0x1001, offset=0x2 -> without C: target 0x1002, trap: mepc=0x300, mcause=0, trap_busy 1 cycle, then pc=trap_vector&~3. With RISCV_C_EXT_EN -> pc=0x1002, no trap.
- ext_trap=1 with ext_cause=2, same cycle as a misaligned JAL at pc=0x400 -> mcause=2, mepc=0x400. Then MRET in update stage -> pc=0x400, mepc unchanged.
- pc=0xFFFF_FFFC, normal op -> pc wraps to 0x0. With RISCV_C_EXT_EN and inst_len16=1 at pc=0x10 -> pc=0x12, pc_link=0x12.
- Assert reset during TRAP cycle -> pc=RESET_VECTOR immediately (async), state RUN, and the following cycle does not load trap_vector.
